nwr_traffic_gen: RTL and testbench

Parametrised NWRITE traffic generator: the next-generation stimulus source for the SRIO user-logic path. It drives bursts of write packets into the NWRITE initiator over the AXI4-Stream-style user interface. Packet size, base address, packet count, inter-packet gap and payload pattern are run-time configurable, and the data width is a build-time parameter. AXI handshake rules are enforced: data is held while stalled.

---
 rtl/nwr_tg_pkg.sv | 32 +++
 rtl/nwr_tg_pattern.sv | 60 ++++++
 rtl/nwr_traffic_gen.sv | 205 ++++++++++++++++++++
 tb/tb_nwr_traffic_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nwr_tg_pkg.sv
// Shared types and helpers for the NWRITE traffic generator.
// Holds the FSM state encoding, payload pattern modes and the tkeep mask helper.
package nwr_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_DATA,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        MODE_COUNTER,
        MODE_PRBS31,
        MODE_FIXED,
        MODE_COUNTER_ALT
    } mode_e;

    localparam int unsigned KEEP_MAX = 16;

    // Top r lanes of an nbytes-wide keep field; MSB lane carries the first byte.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned nbytes,
                                                      input int unsigned r);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if ((i < nbytes) && (i + r >= nbytes)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/nwr_tg_pattern.sv
// Payload pattern source: counter, PRBS31 or fixed seed, replicated per 32-bit lane.
// data_o shows the value for the next beat; advance_i steps both generators.
module nwr_tg_pattern
    import nwr_tg_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              advance_i,
    input  mode_e             mode_i,
    input  logic [31:0]       seed_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned LANES = DATA_W / 32;

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] seed_q, seed_d;
    logic [30:0] prbs_q, prbs_d;
    logic [31:0] lane;

    always_comb begin
        cnt_d  = cnt_q;
        seed_d = seed_q;
        prbs_d = prbs_q;
        if (load_i) begin
            cnt_d  = seed_i;
            seed_d = seed_i;
            // An all-zero LFSR state would lock up, so substitute 1.
            prbs_d = (seed_i[30:0] == '0) ? 31'd1 : seed_i[30:0];
        end else if (advance_i) begin
            cnt_d  = cnt_q + 32'd1;
            prbs_d = {prbs_q[29:0], prbs_q[30] ^ prbs_q[27]};
        end

        lane = cnt_q;
        case (mode_i)
            MODE_PRBS31: lane = {1'b0, prbs_q};
            MODE_FIXED:  lane = seed_q;
            default:     lane = cnt_q;
        endcase
    end

    assign data_o = {LANES{lane}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            seed_q <= '0;
            prbs_q <= 31'd1;
        end else begin
            cnt_q  <= cnt_d;
            seed_q <= seed_d;
            prbs_q <= prbs_d;
        end
    end

endmodule

// File: rtl/nwr_traffic_gen.sv
// NWRITE burst traffic generator driving the SRIO user stream interface.
// Shadowed configuration, registered outputs, data held steady while the stream stalls.
module nwr_traffic_gen
    import nwr_tg_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 34,
    parameter int unsigned SIZE_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                log_clk,
    input  logic                log_rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [SIZE_W-1:0]   cfg_size_i,
    input  logic [ADDR_W-1:0]   cfg_addr_i,
    input  logic [CNT_W-1:0]    cfg_pkts_i,
    input  logic [CNT_W-1:0]    cfg_gap_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [31:0]         cfg_seed_i,
    input  logic                nwr_ready_in,
    input  logic                nwr_busy_in,
    input  logic                user_tready_in,
    output logic [ADDR_W-1:0]   user_addr_o,
    output logic [SIZE_W-1:0]   user_tsize_o,
    output logic [DATA_W-1:0]   user_tdata_o,
    output logic                user_tvalid_o,
    output logic [DATA_W/8-1:0] user_tkeep_o,
    output logic                user_tlast_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    pkt_cnt_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LOG2B = $clog2(BYTES);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [SIZE_W-1:0]   size_q, size_d, beat_q, beat_d, last_idx, next_beat;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    pkts_q, pkts_d, gap_q, gap_d, gap_cnt_q, gap_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d, pat_data;
    logic [BYTES-1:0]    tkeep_q, tkeep_d, last_keep;
    logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                pat_load, pat_adv, load_beat;
    int unsigned         last_r;

    assign last_idx  = size_q >> LOG2B;
    assign last_r    = 32'(size_q[LOG2B-1:0]) + 32'd1;
    assign last_keep = BYTES'(keep_mask(BYTES, last_r));

    nwr_tg_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk       (log_clk),
        .rst_n     (log_rst_n),
        .load_i    (pat_load),
        .advance_i (pat_adv),
        .mode_i    (mode_q),
        .seed_i    (cfg_seed_i),
        .data_o    (pat_data)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        size_d    = size_q;
        addr_d    = addr_q;
        pkts_d    = pkts_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        beat_d    = beat_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pat_load  = 1'b0;
        pat_adv   = 1'b0;
        load_beat = 1'b0;
        next_beat = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    size_d    = cfg_size_i;
                    addr_d    = cfg_addr_i;
                    pkts_d    = (cfg_pkts_i == '0) ? CNT_W'(1) : cfg_pkts_i;
                    gap_d     = cfg_gap_i;
                    mode_d    = mode_e'(cfg_mode_i);
                    pkt_cnt_d = '0;
                    busy_d    = 1'b1;
                    pat_load  = 1'b1;
                    state_d   = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (nwr_ready_in && !nwr_busy_in) begin
                    load_beat = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (user_tready_in) begin
                    if (tlast_q) begin
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        tkeep_d   = '0;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        addr_d    = addr_q + ADDR_W'(size_q) + ADDR_W'(1);
                        gap_cnt_d = '0;
                        if ((pkt_cnt_d < pkts_q) && !abort_i) begin
                            state_d = (gap_q != '0) ? ST_GAP : ST_WAIT_RDY;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        load_beat = 1'b1;
                        next_beat = beat_q + SIZE_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (gap_cnt_q + CNT_W'(1) == gap_q) begin
                    gap_cnt_d = '0;
                    state_d   = ST_WAIT_RDY;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pattern steps as each beat is placed on the bus, so it tracks accepted beats.
        if (load_beat) begin
            tvalid_d = 1'b1;
            beat_d   = next_beat;
            tdata_d  = pat_data;
            tlast_d  = (next_beat == last_idx);
            tkeep_d  = tlast_d ? last_keep : '1;
            pat_adv  = 1'b1;
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COUNTER;
            size_q    <= '0;
            addr_q    <= '0;
            pkts_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            pkt_cnt_q <= '0;
            beat_q    <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            pkts_q    <= pkts_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            beat_q    <= beat_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign user_addr_o   = addr_q;
    assign user_tsize_o  = size_q;
    assign user_tdata_o  = tdata_q;
    assign user_tvalid_o = tvalid_q;
    assign user_tkeep_o  = tkeep_q;
    assign user_tlast_o  = tlast_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_nwr_traffic_gen.sv
// Directed bench for nwr_traffic_gen: 64-bit and 128-bit instances, reference pattern model,
// per-beat checks of data/keep/last/address, gaps, abort and reset behaviour.
module tb_nwr_traffic_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start128, abort;
    logic [11:0]  cfg_size;
    logic [33:0]  cfg_addr;
    logic [15:0]  cfg_pkts, cfg_gap;
    logic [1:0]   cfg_mode;
    logic [31:0]  cfg_seed;
    logic         nwr_ready, nwr_busy, tready;

    logic [33:0]  a64, a128;
    logic [11:0]  s64, s128;
    logic [63:0]  d64;
    logic [127:0] d128;
    logic         v64, v128, l64, l128, b64, b128, dn64, dn128;
    logic [7:0]   k64;
    logic [15:0]  k128;
    logic [15:0]  pc64, pc128;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    nwr_traffic_gen #(.DATA_W(64), .ADDR_W(34), .SIZE_W(12), .CNT_W(16)) u64 (
        .log_clk(clk), .log_rst_n(rst_n), .start_i(start), .abort_i(abort),
        .cfg_size_i(cfg_size), .cfg_addr_i(cfg_addr), .cfg_pkts_i(cfg_pkts),
        .cfg_gap_i(cfg_gap), .cfg_mode_i(cfg_mode), .cfg_seed_i(cfg_seed),
        .nwr_ready_in(nwr_ready), .nwr_busy_in(nwr_busy), .user_tready_in(tready),
        .user_addr_o(a64), .user_tsize_o(s64), .user_tdata_o(d64), .user_tvalid_o(v64),
        .user_tkeep_o(k64), .user_tlast_o(l64), .busy_o(b64), .done_o(dn64), .pkt_cnt_o(pc64)
    );

    nwr_traffic_gen #(.DATA_W(128), .ADDR_W(34), .SIZE_W(12), .CNT_W(16)) u128 (
        .log_clk(clk), .log_rst_n(rst_n), .start_i(start128), .abort_i(abort),
        .cfg_size_i(cfg_size), .cfg_addr_i(cfg_addr), .cfg_pkts_i(cfg_pkts),
        .cfg_gap_i(cfg_gap), .cfg_mode_i(cfg_mode), .cfg_seed_i(cfg_seed),
        .nwr_ready_in(nwr_ready), .nwr_busy_in(nwr_busy), .user_tready_in(tready),
        .user_addr_o(a128), .user_tsize_o(s128), .user_tdata_o(d128), .user_tvalid_o(v128),
        .user_tkeep_o(k128), .user_tlast_o(l128), .busy_o(b128), .done_o(dn128), .pkt_cnt_o(pc128)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one burst on the 64-bit instance and checks every presented beat against the model.
    task automatic run64(input int unsigned size_m1, input int unsigned pkts_cfg,
                         input int unsigned gap, input logic [33:0] addr0,
                         input logic [1:0] mode, input logic [31:0] seed, input bit rnd,
                         input int unsigned abort_pkt, input int unsigned exp_pkts);
        int unsigned last_idx, r, beat, pkts, dones, idle;
        logic [7:0]  lmask;
        logic [31:0] cnt, lane;
        logic [30:0] prbs;
        logic [33:0] eaddr;
        bit          seen_valid, in_gap;
        last_idx = size_m1 >> 3;
        r        = (size_m1 & 7) + 1;
        lmask    = 8'hFF << (8 - r);
        @(negedge clk);
        cfg_size = 12'(size_m1);
        cfg_pkts = 16'(pkts_cfg);
        cfg_gap  = 16'(gap);
        cfg_addr = addr0;
        cfg_mode = mode;
        cfg_seed = seed;
        start    = 1'b1;
        cnt   = seed;
        prbs  = (seed[30:0] == 31'd0) ? 31'd1 : seed[30:0];
        eaddr = addr0;
        beat = 0; pkts = 0; dones = 0; idle = 0;
        seen_valid = 1'b0; in_gap = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_pkt != 0 && pkts + 1 == abort_pkt && v64) abort = 1'b1;
            if (dn64) begin
                dones++;
                chk("done_busy_low", b64, 0);
                chk("done_pkt_cnt", pc64, exp_pkts);
                break;
            end
            if (v64) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    chk("first_beat_latency", cyc, 1);
                end
                if (in_gap) begin
                    chk("gap_idle_cycles", idle, gap + 1);
                    in_gap = 1'b0;
                end
                case (mode)
                    2'd1:    lane = {1'b0, prbs};
                    2'd2:    lane = seed;
                    default: lane = cnt;
                endcase
                chk("tdata", d64, {lane, lane});
                chk("tkeep", k64, (beat == last_idx) ? lmask : 8'hFF);
                chk("tlast", l64, beat == last_idx);
                chk("addr", a64, eaddr);
                if (beat == 0) chk("tsize", s64, size_m1);
                if (tready) begin
                    cnt  = cnt + 1;
                    prbs = {prbs[29:0], prbs[30] ^ prbs[27]};
                    if (beat == last_idx) begin
                        beat = 0;
                        pkts++;
                        eaddr = eaddr + 34'(size_m1 + 1);
                        in_gap = 1'b1;
                        idle = 0;
                    end else begin
                        beat++;
                    end
                end
            end else if (in_gap) begin
                idle++;
            end
        end
        abort  = 1'b0;
        tready = 1'b1;
        chk("done_pulses", dones, 1);
        chk("packets_sent", pkts, exp_pkts);
    endtask

    initial begin
        int unsigned k, dones;
        rst_n = 1'b0; start = 1'b0; start128 = 1'b0; abort = 1'b0;
        cfg_size = '0; cfg_addr = '0; cfg_pkts = '0; cfg_gap = '0; cfg_mode = '0; cfg_seed = '0;
        nwr_ready = 1'b1; nwr_busy = 1'b0; tready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tvalid", v64, 0);
        chk("rst_tkeep", k64, 0);
        chk("rst_tsize", s64, 0);
        chk("rst_addr", a64, 0);
        chk("rst_busy_done", {b64, dn64}, 0);
        chk("rst_pkt_cnt", pc64, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {v64, b64, v128, b128}, 0);

        // 247-byte single packet: 31 beats, last keep FE
        run64(246, 1, 0, 34'h0_0000_1000, 2'd0, 32'd0, 1'b0, 0, 1);

        // 128-bit: 513 bytes -> 33 beats, last keep 16'h8000
        @(negedge clk);
        cfg_size = 12'd512; cfg_pkts = 16'd1; cfg_gap = '0; cfg_addr = '0;
        cfg_mode = 2'd0; cfg_seed = 32'd0; start128 = 1'b1;
        k = 0; dones = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start128 = 1'b0;
            if (dn128) begin
                dones++;
                break;
            end
            if (v128) begin
                chk("w128_tdata", d128, {4{k}});
                chk("w128_tkeep", k128, (k == 32) ? 16'h8000 : 16'hFFFF);
                chk("w128_tlast", l128, k == 32);
                k++;
            end
        end
        chk("w128_beats", k, 33);
        chk("w128_done", dones, 1);

        // Four packets wrapping the 34-bit address space, counter alias mode 3
        run64(255, 4, 0, 34'h3_FFFF_FF00, 2'd3, 32'h0000_0100, 1'b0, 0, 4);

        // PRBS31 with random stalls, then the all-zero seed substitution
        run64(100, 2, 2, 34'h0_0040_0000, 2'd1, 32'h1234_ACE1, 1'b1, 0, 2);
        run64(15, 1, 0, 34'h0, 2'd1, 32'h8000_0000, 1'b0, 0, 1);

        // Fixed pattern, one full beat, packet count 0 treated as 1, random stalls
        run64(7, 0, 0, 34'h0_0000_0040, 2'd2, 32'hDEAD_BEEF, 1'b1, 0, 1);

        // Gap of 5 between three packets, then abort during packet 2
        run64(31, 3, 5, 34'h0_0000_2000, 2'd0, 32'd7, 1'b0, 0, 3);
        run64(31, 3, 5, 34'h0_0000_2000, 2'd0, 32'd7, 1'b0, 2, 2);

        // Initiator not ready / busy holds off the packet; abort there ends the burst
        @(negedge clk);
        nwr_ready = 1'b0; cfg_size = 12'd31; cfg_pkts = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_no_valid", v64, 0);
        chk("wait_busy_high", b64, 1);
        nwr_ready = 1'b1; nwr_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("nwr_busy_blocks", v64, 0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_wait_done", dn64, 1);
        chk("abort_wait_idle", {b64, v64}, 0);
        abort = 1'b0; nwr_busy = 1'b0;
        @(negedge clk);
        chk("done_single_cycle", dn64, 0);

        // Asynchronous reset in the middle of a packet
        @(negedge clk);
        cfg_size = 12'd255; cfg_pkts = 16'd1; cfg_mode = 2'd0; cfg_seed = 32'd0;
        cfg_addr = 34'h0_0000_8000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_valid", v64, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", v64, 0);
        chk("async_rst_outputs", {k64, l64, b64, a64, s64, pc64}, 0);
        chk("async_rst_tdata", d64, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run64(23, 1, 0, 34'h0_0000_0100, 2'd0, 32'd5, 1'b0, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
